// File: rtl/spasrd_32_8_pkg.sv
// Shared definitions for the register-snapshot byte serializer: state encoding,
// transfer geometry and byte-selection helper.
package spasrd_32_8_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int BEATS  = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int NREGS  = 4;

  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                   input logic [1:0]        idx);
    return w[idx*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/spasrd_beatcnt.sv
// Beat counter for one serialized word: advances on each accepted beat and
// wraps back to zero after the final beat, so a new transfer always starts at 0.
module spasrd_beatcnt
  import spasrd_32_8_pkg::*;
(
  input  logic       clk,
  input  logic       reset_l,
  input  logic       en,
  output logic [1:0] beat,
  output logic       last
);

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      beat <= 2'd0;
    end else if (en) begin
      beat <= beat + 2'd1;
    end
  end

  assign last = (beat == 2'(BEATS - 1));

endmodule

// File: rtl/spasrd_32_8.sv
// Snapshots one of four 32-bit registers on request and streams it out as four
// bytes over a valid/ready port; busy reflects the FSM state (SEND).
module spasrd_32_8
  import spasrd_32_8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_l,
  input  logic [NREGS*WORD_W-1:0]   reg_bus,
  input  logic                      rd_req,
  input  logic [1:0]                rd_sel,
  output logic                      rd_ack,
  output logic [BYTE_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic                      dout_last,
  output logic                      busy
);

  // Handshake: a beat transfers on a rising edge where dout_valid and
  // dout_ready are both high; dout/dout_last hold steady while dout_ready is
  // low, and dout_valid is purely registered (never a function of dout_ready).

  state_e              state;
  logic [WORD_W-1:0]   snap;
  logic                valid_q;
  logic                ack_q;
  logic                hs;
  logic [1:0]          beat;
  logic                beat_last;
  logic [1:0]          byte_idx;

  assign hs = valid_q & dout_ready;

  spasrd_beatcnt u_beatcnt (
    .clk     (clk),
    .reset_l (reset_l),
    .en      (hs),
    .beat    (beat),
    .last    (beat_last)
  );

  // Requests seen in SEND (including on the final handshake) are ignored, which
  // guarantees at least one idle cycle between transfers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state   <= IDLE;
      snap    <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            snap    <= reg_bus[rd_sel*WORD_W +: WORD_W];
            ack_q   <= 1'b1;
            valid_q <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (hs && beat_last) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign byte_idx   = LSB_FIRST ? beat : (2'd3 - beat);
  assign dout       = word_byte(snap, byte_idx);
  assign dout_valid = valid_q;
  assign dout_last  = valid_q & beat_last;
  assign rd_ack     = ack_q;
  assign busy       = (state == SEND);

endmodule

// File: tb/tb_spasrd_32_8.sv
// Bench for spasrd_32_8: drives an LSB-first and an MSB-first instance in
// parallel and checks both against byte queues built from the requested word.
module tb_spasrd_32_8;

  logic        clk;
  logic        reset_l;
  logic [31:0] regs [4];
  logic [127:0] reg_bus;
  logic        rd_req;
  logic [1:0]  rd_sel;
  logic        dout_ready;

  logic        rd_ack,     rd_ack_m;
  logic [7:0]  dout,       dout_m;
  logic        dout_valid, dout_valid_m;
  logic        dout_last,  dout_last_m;
  logic        busy,       busy_m;

  int n_tests;
  int n_fail;

  assign reg_bus = {regs[3], regs[2], regs[1], regs[0]};

  spasrd_32_8 #(.LSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .reg_bus    (reg_bus),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_ack     (rd_ack),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy)
  );

  spasrd_32_8 #(.LSB_FIRST(1'b0)) dut_m (
    .clk        (clk),
    .reset_l    (reset_l),
    .reg_bus    (reg_bus),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_ack     (rd_ack_m),
    .dout       (dout_m),
    .dout_valid (dout_valid_m),
    .dout_ready (dout_ready),
    .dout_last  (dout_last_m),
    .busy       (busy_m)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"},  32'(dout_valid),   32'd0);
    chk({tag, "_valid_m"},32'(dout_valid_m), 32'd0);
    chk({tag, "_busy"},   32'(busy),         32'd0);
    chk({tag, "_busy_m"}, 32'(busy_m),       32'd0);
    chk({tag, "_ack"},    32'(rd_ack),       32'd0);
    chk({tag, "_last"},   32'(dout_last),    32'd0);
  endtask

  // One transfer, called at a negedge with the DUT idle. Returns at the
  // negedge of the idle bubble after the final beat.
  // mut_mode: 0 none, 1 regs[sel]=FFFFFFFF after ack, 2 randomize all regs every cycle.
  task automatic do_xfer(input logic [1:0] sel, input int stall_beat, input int stall_len,
                         input bit rand_ready, input bit hold_req, input int mut_mode);
    logic [31:0] w;
    logic [7:0]  q_l[$];
    logic [7:0]  q_m[$];
    int cyc;
    int stalled;
    int beat_no;
    w = regs[sel];
    for (int b = 0; b < 4; b++) begin
      q_l.push_back(w[8*b +: 8]);
      q_m.push_front(w[8*b +: 8]);
    end
    rd_req = 1'b1;
    rd_sel = sel;
    tick();
    chk("ack",   32'(rd_ack),   32'd1);
    chk("ack_m", 32'(rd_ack_m), 32'd1);
    if (!hold_req) rd_req = 1'b0;
    if (mut_mode == 1) regs[sel] = 32'hFFFF_FFFF;
    cyc = 0;
    stalled = 0;
    beat_no = 0;
    while (q_l.size() > 0 && cyc < 64) begin
      if (cyc > 0) chk("ack_once", 32'(rd_ack), 32'd0);
      chk("valid",    32'(dout_valid),   32'd1);
      chk("valid_m",  32'(dout_valid_m), 32'd1);
      chk("busy",     32'(busy),         32'd1);
      chk("dout_lsb", 32'(dout),         32'(q_l[0]));
      chk("dout_msb", 32'(dout_m),       32'(q_m[0]));
      chk("last",     32'(dout_last),    32'(q_l.size() == 1));
      chk("last_m",   32'(dout_last_m),  32'(q_m.size() == 1));
      if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
      else if (beat_no == stall_beat && stalled < stall_len) begin
        dout_ready = 1'b0;
        stalled++;
      end else dout_ready = 1'b1;
      if (dout_ready) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
        beat_no++;
      end
      if (mut_mode == 2) for (int r = 0; r < 4; r++) regs[r] = $urandom;
      tick();
      cyc++;
    end
    chk("timeout", 32'(q_l.size()), 32'd0);
    chk_idle_outputs("bubble");
    dout_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    n_tests = 0;
    n_fail  = 0;
    reset_l = 1'b0;
    rd_req = 1'b0;
    rd_sel = 2'd0;
    dout_ready = 1'b1;
    for (int r = 0; r < 4; r++) regs[r] = 32'd0;
    repeat (3) tick();
    chk_idle_outputs("reset");
    chk("reset_dout",   32'(dout),   32'd0);
    chk("reset_dout_m", 32'(dout_m), 32'd0);
    reset_l = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // Basic read of register 2, continuous ready
    regs[2] = 32'h8765_4321;
    do_xfer(2'd2, -1, 0, 1'b0, 1'b0, 0);
    tick();

    // Three-cycle stall on beat 1
    do_xfer(2'd2, 1, 3, 1'b0, 1'b0, 0);
    tick();

    // Register changed after ack, request held through SEND, then re-served
    regs[2] = 32'h8765_4321;
    do_xfer(2'd2, -1, 0, 1'b0, 1'b1, 1);
    do_xfer(2'd2, -1, 0, 1'b0, 1'b0, 0);
    tick();

    // Back-to-back: one idle bubble between transfers
    regs[0] = 32'h0000_0001;
    regs[3] = 32'hA5A5_5A5A;
    do_xfer(2'd0, -1, 0, 1'b0, 1'b1, 0);
    do_xfer(2'd3, -1, 0, 1'b0, 1'b0, 0);
    tick();

    // Reset asserted during beat 2
    regs[1] = $urandom;
    w = regs[1];
    rd_req = 1'b1;
    rd_sel = 2'd1;
    tick();
    chk("rst_ack", 32'(rd_ack), 32'd1);
    rd_req = 1'b0;
    chk("rst_b0", 32'(dout), 32'(w[7:0]));
    tick();
    chk("rst_b1", 32'(dout), 32'(w[15:8]));
    tick();
    chk("rst_b2", 32'(dout), 32'(w[23:16]));
    #1 reset_l = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    chk("mid_reset_dout",   32'(dout),   32'd0);
    chk("mid_reset_dout_m", 32'(dout_m), 32'd0);
    tick();
    tick();
    reset_l = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_idle_outputs("after_reset");
    end

    // Randomized transfers with random backpressure and register churn
    for (int i = 0; i < 24; i++) begin
      for (int r = 0; r < 4; r++) regs[r] = $urandom;
      do_xfer(2'($urandom_range(0, 3)), -1, 0, 1'b1, 1'b0,
              ($urandom_range(0, 1) == 1) ? 2 : 0);
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk_idle_outputs("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
